// File: rtl/fpsub_iter.sv
// Multi-cycle IEEE-754 single-precision subtractor, c = a - b.
// Alignment and normalization shift one bit per cycle behind a valid/ready handshake.
module fpsub_iter #(
  parameter int unsigned MAX_ALIGN = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] c,
  output logic        ov,
  output logic        uf,
  output logic        zero
);

  localparam int unsigned DW = $clog2(MAX_ALIGN + 1);
  localparam logic [7:0]  MAX_ALIGN_W = 8'(MAX_ALIGN);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    OP,
    NORM,
    DONE
  } state_t;

  state_t         state_q;
  logic           signX_q;
  logic           signY_q;
  logic [7:0]     expX_q;
  logic [23:0]    mantX_q;
  logic [23:0]    mantY_q;
  logic [DW-1:0]  d_q;
  logic [31:0]    c_q;
  logic           ov_q;
  logic           uf_q;
  logic           zero_q;
  logic           outValid_q;

  logic           signA;
  logic           signB;
  logic [7:0]     expA;
  logic [7:0]     expB;
  logic [23:0]    mantA;
  logic [23:0]    mantB;
  logic           aIsX;
  logic           signX_d;
  logic           signY_d;
  logic [7:0]     expX_d;
  logic [7:0]     expY_d;
  logic [23:0]    mantX_d;
  logic [23:0]    mantY_d;
  logic [7:0]     expDiff;
  logic [DW-1:0]  d_d;
  logic           specialIn;

  logic           sameSign;
  logic [24:0]    opRes;
  logic [7:0]     expInc;
  logic [23:0]    normMant;
  logic [7:0]     expDec;

  // Unpack both operands (b sign flipped, denormals flushed) and order them by magnitude.
  always_comb begin
    signA     = a[31];
    signB     = ~b[31];
    expA      = a[30:23];
    expB      = b[30:23];
    mantA     = (expA == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    mantB     = (expB == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    specialIn = (expA == 8'hFF) || (expB == 8'hFF);
    aIsX      = ({expA, mantA} >= {expB, mantB});
    signX_d   = aIsX ? signA : signB;
    signY_d   = aIsX ? signB : signA;
    expX_d    = aIsX ? expA  : expB;
    expY_d    = aIsX ? expB  : expA;
    mantX_d   = aIsX ? mantA : mantB;
    mantY_d   = aIsX ? mantB : mantA;
    expDiff   = expX_d - expY_d;
    d_d       = '0;
    if (mantY_d != 24'd0) begin
      d_d = (expDiff > MAX_ALIGN_W) ? DW'(MAX_ALIGN) : DW'(expDiff);
    end
  end

  // Shared datapath for the OP and NORM steps.
  always_comb begin
    sameSign = (signX_q == signY_q);
    opRes    = sameSign ? ({1'b0, mantX_q} + {1'b0, mantY_q})
                        : ({1'b0, mantX_q} - {1'b0, mantY_q});
    expInc   = expX_q + 8'd1;
    normMant = {mantX_q[22:0], 1'b0};
    expDec   = expX_q - 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      signX_q    <= 1'b0;
      signY_q    <= 1'b0;
      expX_q     <= 8'd0;
      mantX_q    <= 24'd0;
      mantY_q    <= 24'd0;
      d_q        <= '0;
      c_q        <= 32'd0;
      ov_q       <= 1'b0;
      uf_q       <= 1'b0;
      zero_q     <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            signX_q <= signX_d;
            signY_q <= signY_d;
            expX_q  <= expX_d;
            mantX_q <= mantX_d;
            mantY_q <= mantY_d;
            d_q     <= d_d;
            ov_q    <= 1'b0;
            uf_q    <= 1'b0;
            zero_q  <= 1'b0;
            if (specialIn) begin
              c_q        <= {signA, 8'hFF, 23'd0};
              ov_q       <= 1'b1;
              outValid_q <= 1'b1;
              state_q    <= DONE;
            end else if (d_d != '0) begin
              state_q <= ALIGN;
            end else begin
              state_q <= OP;
            end
          end
        end

        ALIGN: begin
          mantY_q <= mantY_q >> 1;
          d_q     <= d_q - 1'b1;
          if (d_q == DW'(1)) begin
            state_q <= OP;
          end
        end

        OP: begin
          if (opRes == 25'd0) begin
            // Exact cancellation gives +0; only -0 - +0 keeps a negative zero.
            c_q        <= sameSign ? {signX_q, 31'd0} : 32'd0;
            zero_q     <= 1'b1;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else if (opRes[24]) begin
            if (expInc == 8'hFF) begin
              c_q  <= {signX_q, 8'hFF, 23'd0};
              ov_q <= 1'b1;
            end else begin
              c_q <= {signX_q, expInc, opRes[23:1]};
            end
            expX_q     <= expInc;
            mantX_q    <= opRes[24:1];
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else if (opRes[23]) begin
            c_q        <= {signX_q, expX_q, opRes[22:0]};
            mantX_q    <= opRes[23:0];
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            mantX_q <= opRes[23:0];
            state_q <= NORM;
          end
        end

        NORM: begin
          if (expX_q <= 8'd1) begin
            c_q        <= {signX_q, 31'd0};
            uf_q       <= 1'b1;
            zero_q     <= 1'b1;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            mantX_q <= normMant;
            expX_q  <= expDec;
            if (normMant[23]) begin
              c_q        <= {signX_q, expDec, normMant[22:0]};
              outValid_q <= 1'b1;
              state_q    <= DONE;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end

        default: begin
          outValid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = outValid_q;
  assign c         = c_q;
  assign ov        = ov_q;
  assign uf        = uf_q;
  assign zero      = zero_q;

endmodule
